mod_offset_gen: RTL and testbench

- Parametrised, pipelined modulation-offset generator for the DDS core; generalises the fixed PM offset stage.
- Converts an offset-binary modulating sample into a signed phase offset (PM) or frequency offset (FM).
- Applies round-half-up scaling and saturation, with a valid-strobe handshake and pipeline flush on mode change.
- Feeds the phase accumulator adder (freq_ofs) and the phase-to-amplitude address adder (phase_ofs).

---
 rtl/dds_pkg.sv | 29 ++
 rtl/mod_scale_sat.sv | 46 ++++
 rtl/mod_offset_gen.sv | 109 ++++++++++
 tb/tb_mod_offset_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: modulation mode codes and fixed-point helpers
// used by the modulation-offset path.
package dds_pkg;

    localparam logic [2:0] MODE_PM = 3'b011;
    localparam logic [2:0] MODE_FM = 3'b010;

    // Offset-binary to two's complement: flip the MSB of a w-bit word.
    function automatic logic [63:0] ob_to_signed(input logic [63:0] x, input int unsigned w);
        return x ^ (64'd1 << (w - 1));
    endfunction

    // Round half toward +inf while dropping 'shift' LSBs, then clamp to a
    // signed out_w-bit range. Caller truncates the result to out_w bits.
    function automatic logic signed [63:0] round_shift_sat(input logic signed [63:0] p,
                                                           input int unsigned      shift,
                                                           input int unsigned      out_w);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (r > max_v) return max_v;
        if (r < min_v) return min_v;
        return r;
    endfunction

endpackage

// File: rtl/mod_scale_sat.sv
// One scaling lane: registered sample/deviation, registered signed product,
// then combinational round-half-up and saturation to OUT_W bits.
module mod_scale_sat
    import dds_pkg::*;
#(
    parameter int unsigned MOD_W = 16,
    parameter int unsigned DEV_W = 16,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic [MOD_W-1:0] s,
    input  logic [DEV_W-1:0] dev,
    output logic [OUT_W-1:0] r
);

    localparam int unsigned PROD_W = MOD_W + DEV_W + 1;

    logic signed [MOD_W-1:0]  s_q;
    logic        [DEV_W-1:0]  dev_q;
    logic signed [PROD_W-1:0] prod_q;

    // Stage 1: capture the signed sample and its deviation word on a strobe.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            dev_q <= '0;
        end else if (en) begin
            s_q   <= $signed(s);
            dev_q <= dev;
        end
    end

    // Stage 2: signed sample times zero-extended (non-negative) deviation.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= PROD_W'(s_q) * PROD_W'($signed({1'b0, dev_q}));
        end
    end

    assign r = OUT_W'(round_shift_sat(64'(prod_q), MOD_W - 1, OUT_W));

endmodule

// File: rtl/mod_offset_gen.sv
// Modulation-offset generator: offset-binary sample -> scaled, rounded and
// saturated phase (PM) or frequency (FM) offset, three-cycle latency, with
// a pipeline flush whenever the mode input changes.
module mod_offset_gen #(
    parameter int unsigned MOD_W   = 16,
    parameter int unsigned DEV_W   = 16,
    parameter int unsigned PHASE_W = 12,
    parameter int unsigned FREQ_W  = 32,
    parameter logic [2:0]  MODE_PM = 3'b011,
    parameter logic [2:0]  MODE_FM = 3'b010
) (
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic [2:0]         mode,
    input  logic [MOD_W-1:0]   mod_sample,
    input  logic               mod_valid,
    input  logic [DEV_W-1:0]   pd,
    input  logic [DEV_W-1:0]   fd,
    output logic [PHASE_W-1:0] phase_ofs,
    output logic [FREQ_W-1:0]  freq_ofs,
    output logic               out_valid
);

    import dds_pkg::*;

    logic [2:0]         mode_q;
    logic [2:0]         mode1;
    logic [2:0]         mode2;
    logic               v1;
    logic               v2;
    logic               flush;
    logic [MOD_W-1:0]   s_in;
    logic [PHASE_W-1:0] r_pm;
    logic [FREQ_W-1:0]  r_fm;

    assign flush = (mode != mode_q);
    assign s_in  = MOD_W'(ob_to_signed(64'(mod_sample), MOD_W));

    // Valid/mode pipeline alongside the lanes; a mode change kills in-flight samples.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            mode1  <= '0;
            mode2  <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
        end else begin
            mode_q <= mode;
            v1     <= mod_valid & ~flush;
            v2     <= v1 & ~flush;
            if (mod_valid) mode1 <= mode;
            if (v1)        mode2 <= mode1;
        end
    end

    mod_scale_sat #(
        .MOD_W (MOD_W),
        .DEV_W (DEV_W),
        .OUT_W (PHASE_W)
    ) u_pm_lane (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (mod_valid),
        .s        (s_in),
        .dev      (pd),
        .r        (r_pm)
    );

    mod_scale_sat #(
        .MOD_W (MOD_W),
        .DEV_W (DEV_W),
        .OUT_W (FREQ_W)
    ) u_fm_lane (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (mod_valid),
        .s        (s_in),
        .dev      (fd),
        .r        (r_fm)
    );

    // Output stage: flush forces zero and wins over a completing sample.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            phase_ofs <= '0;
            freq_ofs  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            phase_ofs <= '0;
            freq_ofs  <= '0;
            out_valid <= 1'b0;
        end else if (v2) begin
            out_valid <= 1'b1;
            if (mode2 == MODE_PM) begin
                phase_ofs <= r_pm;
                freq_ofs  <= '0;
            end else if (mode2 == MODE_FM) begin
                phase_ofs <= '0;
                freq_ofs  <= r_fm;
            end else begin
                phase_ofs <= '0;
                freq_ofs  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_offset_gen.sv
// Randomised and directed bench for mod_offset_gen against a transaction-level
// reference model (real-valued rounding, queue of pending results).
module tb_mod_offset_gen;

    localparam int unsigned MOD_W   = 16;
    localparam int unsigned DEV_W   = 16;
    localparam int unsigned PHASE_W = 12;
    localparam int unsigned FREQ_W  = 32;
    localparam logic [2:0]  PM      = 3'b011;
    localparam logic [2:0]  FM      = 3'b010;

    logic               clk_100M   = 1'b0;
    logic               rst_n      = 1'b1;
    logic [2:0]         mode       = 3'b000;
    logic [MOD_W-1:0]   mod_sample = 16'h8000;
    logic               mod_valid  = 1'b0;
    logic [DEV_W-1:0]   pd         = '0;
    logic [DEV_W-1:0]   fd         = '0;
    logic [PHASE_W-1:0] phase_ofs;
    logic [FREQ_W-1:0]  freq_ofs;
    logic               out_valid;

    mod_offset_gen #(
        .MOD_W   (MOD_W),
        .DEV_W   (DEV_W),
        .PHASE_W (PHASE_W),
        .FREQ_W  (FREQ_W),
        .MODE_PM (PM),
        .MODE_FM (FM)
    ) dut (
        .clk_100M   (clk_100M),
        .rst_n      (rst_n),
        .mode       (mode),
        .mod_sample (mod_sample),
        .mod_valid  (mod_valid),
        .pd         (pd),
        .fd         (fd),
        .phase_ofs  (phase_ofs),
        .freq_ofs   (freq_ofs),
        .out_valid  (out_valid)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        int     due;
        longint ph;
        longint fr;
    } exp_t;

    exp_t       pend[$];
    int         checks    = 0;
    int         failures  = 0;
    int         edge_idx  = 0;
    logic [2:0] prev_mode = 3'b000;
    longint     exp_ph    = 0;
    longint     exp_fr    = 0;
    longint     exp_ov    = 0;
    logic [2:0] rm;
    logic [15:0] smp;
    logic [15:0] rp;
    logic [15:0] rf;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Ideal value: floor(s*dev/2^15 + 1/2), clamped to a signed w-bit range.
    function automatic longint scale(input longint s, input longint dev, input int w);
        real    x;
        longint r;
        longint hi;
        longint lo;
        x  = $floor((s * dev + 16384) / 32768.0);
        r  = longint'(x);
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic check_outputs();
        check($sformatf("out_valid@%0d", edge_idx), longint'(out_valid), exp_ov);
        check($sformatf("phase_ofs@%0d", edge_idx), longint'($signed(phase_ofs)), exp_ph);
        check($sformatf("freq_ofs@%0d", edge_idx), longint'($signed(freq_ofs)), exp_fr);
    endtask

    task automatic step(input logic [2:0] m, input bit mv, input logic [15:0] s,
                        input logic [15:0] p, input logic [15:0] f);
        exp_t   e;
        longint sv;
        @(negedge clk_100M);
        mode       = m;
        mod_valid  = mv;
        mod_sample = s;
        pd         = p;
        fd         = f;
        @(posedge clk_100M);
        if (m != prev_mode) begin
            pend.delete();
            exp_ph = 0;
            exp_fr = 0;
            exp_ov = 0;
        end else begin
            exp_ov = 0;
            if (pend.size() > 0 && pend[0].due == edge_idx) begin
                e      = pend.pop_front();
                exp_ph = e.ph;
                exp_fr = e.fr;
                exp_ov = 1;
            end
            if (mv) begin
                sv    = longint'(s) - 32768;
                e.due = edge_idx + 2;
                e.ph  = (m == PM) ? scale(sv, longint'(p), PHASE_W) : 0;
                e.fr  = (m == FM) ? scale(sv, longint'(f), FREQ_W) : 0;
                pend.push_back(e);
            end
        end
        prev_mode = m;
        edge_idx++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [2:0] m);
        for (int i = 0; i < n; i++) step(m, 1'b0, 16'h8000, pd, fd);
    endtask

    task automatic async_reset();
        @(posedge clk_100M);
        #3 rst_n = 1'b0;
        #1;
        pend.delete();
        exp_ph    = 0;
        exp_fr    = 0;
        exp_ov    = 0;
        prev_mode = 3'b000;
        check_outputs();
        @(posedge clk_100M);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        check_outputs();
        @(posedge clk_100M);
        #2 rst_n = 1'b1;

        idle(2, 3'b000);

        // PM full scale
        idle(2, PM);
        step(PM, 1'b1, 16'hFFFF, 16'd2047, 16'd0);
        step(PM, 1'b1, 16'h0000, 16'd2047, 16'd0);
        idle(4, PM);

        // PM saturation and zero sample
        step(PM, 1'b1, 16'hFFFF, 16'd4000, 16'd0);
        step(PM, 1'b1, 16'h0000, 16'd4000, 16'd0);
        step(PM, 1'b1, 16'h8000, 16'd4000, 16'd0);
        idle(4, PM);

        // FM rounding of +/-1.5
        idle(2, FM);
        step(FM, 1'b1, 16'hC000, 16'd0, 16'd3);
        step(FM, 1'b1, 16'h4000, 16'd0, 16'd3);
        idle(4, FM);

        // back-to-back throughput then hold
        idle(2, PM);
        step(PM, 1'b1, 16'h8000, 16'd100, 16'd0);
        step(PM, 1'b1, 16'hFFFF, 16'd100, 16'd0);
        step(PM, 1'b1, 16'h0000, 16'd100, 16'd0);
        step(PM, 1'b1, 16'h8000, 16'd100, 16'd0);
        idle(6, PM);

        // mode-change flush with two samples in flight
        step(PM, 1'b1, 16'hFFFF, 16'd100, 16'd0);
        idle(3, PM);
        step(PM, 1'b1, 16'hFFFF, 16'd100, 16'd0);
        step(PM, 1'b1, 16'h0000, 16'd100, 16'd0);
        step(3'b000, 1'b1, 16'hFFFF, 16'd100, 16'd100);
        step(3'b000, 1'b1, 16'hFFFF, 16'd100, 16'd100);
        step(3'b000, 1'b1, 16'h0000, 16'd100, 16'd100);
        idle(4, 3'b000);

        // async reset mid-stream
        idle(2, PM);
        step(PM, 1'b1, 16'hFFFF, 16'd500, 16'd0);
        step(PM, 1'b1, 16'h0000, 16'd500, 16'd0);
        async_reset();
        step(PM, 1'b0, 16'h8000, 16'd500, 16'd0);
        step(PM, 1'b1, 16'hFFFF, 16'd500, 16'd0);
        idle(4, PM);

        // randomised traffic with occasional mode changes
        rm = PM;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0:       rm = PM;
                    1:       rm = FM;
                    2:       rm = 3'b000;
                    default: rm = 3'($urandom);
                endcase
            end
            case ($urandom_range(7))
                0:       smp = 16'h0000;
                1:       smp = 16'hFFFF;
                2:       smp = 16'h8000;
                default: smp = 16'($urandom);
            endcase
            rp = ($urandom_range(1) == 0) ? 16'($urandom_range(4095)) : 16'($urandom);
            rf = ($urandom_range(3) == 0) ? 16'($urandom_range(7)) : 16'($urandom);
            step(rm, ($urandom_range(3) != 0), smp, rp, rf);
        end
        idle(4, rm);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
